// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file port controller.
// The struct describes one pending write held in the write queue.
package regfile_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // Register x0 is hard-wired to zero; writes to it are dropped.
  localparam logic [RF_ADDR_W-1:0] X0_ADDR = '0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Bus bundle between the datapath, the port controller and the register file.
// The slave modport is the controller. The master modport is the
// environment: it plays both the datapath requester and the register-file
// read port.
interface regfile_port_ctrl_if
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  // write-back request channel
  logic              WrReqValid;
  logic              WrReqReady;
  logic [ADDR_W-1:0] WrReqAddr;
  logic [DATA_W-1:0] WrReqData;

  // operand read request / response channel
  logic              RdReqValid;
  logic              RdReqReady;
  logic [ADDR_W-1:0] RdReqAddr1;
  logic [ADDR_W-1:0] RdReqAddr2;
  logic              RdRespValid;
  logic [DATA_W-1:0] RdRespData1;
  logic [DATA_W-1:0] RdRespData2;

  // register-file ports
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport slave (
    input  WrReqValid, WrReqAddr, WrReqData,
    input  RdReqValid, RdReqAddr1, RdReqAddr2,
    input  ReadData1, ReadData2,
    output WrReqReady, RdReqReady,
    output RdRespValid, RdRespData1, RdRespData2,
    output RegWrite, WriteReg, WriteData,
    output ReadReg1, ReadReg2
  );

  modport master (
    output WrReqValid, WrReqAddr, WrReqData,
    output RdReqValid, RdReqAddr1, RdReqAddr2,
    output ReadData1, ReadData2,
    input  WrReqReady, RdReqReady,
    input  RdRespValid, RdRespData1, RdRespData2,
    input  RegWrite, WriteReg, WriteData,
    input  ReadReg1, ReadReg2
  );

endinterface

// File: rtl/regfile_wq_fifo.sv
// Synchronous write queue for pending register writes.
// It also exposes every entry ordered youngest-first (index 0 is the most
// recent push), each with a valid flag, so the bypass compare can scan the
// entries in priority order without knowing the pointers.
module regfile_wq_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  wq_entry_t                   i_push_entry,
  input  logic                        i_pop,
  output wq_entry_t                   o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output wq_entry_t [DEPTH-1:0]       o_age_entry,
  output logic      [DEPTH-1:0]       o_age_vld
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // Overflowing pushes and underflowing pops are ignored.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Youngest-first view: slot k is the entry pushed k pushes ago.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign o_age_entry[k] = r_mem[r_wr_ptr - PTR_W'(k) - PTR_W'(1)];
    assign o_age_vld[k]   = (r_count > CNT_W'(k));
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Initiator-side controller for the 32x32 register file.
// Write-back requests are queued and drained one per cycle into registered
// RegWrite/WriteReg/WriteData. Operand reads register ReadReg1/ReadReg2 and
// respond one cycle later.
// Optional feature macro: REGFILE_PORT_BYPASS_EN
//   defined   : read-after-write bypass from the queue and output register;
//               reads are never stalled.
//   undefined : no comparators; reads stall until all pending writes have
//               committed to the register file.
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                Clk,
  input  logic                Reset,
  regfile_port_ctrl_if.slave  bus
);

  wq_entry_t             w_push_entry;
  wq_entry_t             w_head;
  wq_entry_t [DEPTH-1:0] w_age_entry;
  logic      [DEPTH-1:0] w_age_vld;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd_fire;

  logic                  r_RegWrite;
  logic [ADDR_W-1:0]     r_WriteReg;
  logic [DATA_W-1:0]     r_WriteData;
  logic [ADDR_W-1:0]     r_ReadReg1;
  logic [ADDR_W-1:0]     r_ReadReg2;
  logic                  r_RdRespValid;

  // Write side: ready depends only on registered occupancy, so a full queue
  // blocks even on a cycle where the head is being popped.
  assign bus.WrReqReady = !Reset && !w_full;
  assign w_wr_fire      = bus.WrReqValid && bus.WrReqReady;
  assign w_push         = w_wr_fire && (bus.WrReqAddr != X0_ADDR);
  assign w_push_entry   = '{addr: bus.WrReqAddr, data: bus.WrReqData};
  assign w_pop          = !w_empty;

  regfile_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_wq (
    .i_clk        (Clk),
    .i_rst        (Reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_age_entry  (w_age_entry),
    .o_age_vld    (w_age_vld)
  );

`ifdef REGFILE_PORT_BYPASS_EN
  assign bus.RdReqReady = !Reset;
`else
  // Without bypass, a read may only proceed once nothing is queued or in
  // flight, so the register file itself is always current.
  assign bus.RdReqReady = !Reset && w_empty && !r_RegWrite;
`endif

  assign w_rd_fire = bus.RdReqValid && bus.RdReqReady;

  // Register-file write port and read-address registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_RegWrite    <= 1'b0;
      r_WriteReg    <= '0;
      r_WriteData   <= '0;
      r_ReadReg1    <= '0;
      r_ReadReg2    <= '0;
      r_RdRespValid <= 1'b0;
    end else begin
      r_RegWrite <= w_pop;
      if (w_pop) begin
        r_WriteReg  <= w_head.addr;
        r_WriteData <= w_head.data;
      end
      if (w_rd_fire) begin
        r_ReadReg1 <= bus.RdReqAddr1;
        r_ReadReg2 <= bus.RdReqAddr2;
      end
      r_RdRespValid <= w_rd_fire;
    end
  end

  assign bus.RegWrite    = r_RegWrite;
  assign bus.WriteReg    = r_WriteReg;
  assign bus.WriteData   = r_WriteData;
  assign bus.ReadReg1    = r_ReadReg1;
  assign bus.ReadReg2    = r_ReadReg2;
  assign bus.RdRespValid = r_RdRespValid;

`ifdef REGFILE_PORT_BYPASS_EN
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_byp1;
  logic [DATA_W-1:0] w_byp2;
  logic              r_byp_hit1;
  logic              r_byp_hit2;
  logic [DATA_W-1:0] r_byp_val1;
  logic [DATA_W-1:0] r_byp_val2;

  // Bypass search: output register is lowest priority, then queue entries
  // oldest to youngest so the youngest match overwrites any older one.
  // Entries pushed at the accept edge are not yet visible, which gives the
  // read the state before a same-cycle write.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_byp1 = '0;
    w_byp2 = '0;
    if (r_RegWrite && (r_WriteReg == bus.RdReqAddr1)) begin
      w_hit1 = 1'b1;
      w_byp1 = r_WriteData;
    end
    if (r_RegWrite && (r_WriteReg == bus.RdReqAddr2)) begin
      w_hit2 = 1'b1;
      w_byp2 = r_WriteData;
    end
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_age_vld[k] && (w_age_entry[k].addr == bus.RdReqAddr1)) begin
        w_hit1 = 1'b1;
        w_byp1 = w_age_entry[k].data;
      end
      if (w_age_vld[k] && (w_age_entry[k].addr == bus.RdReqAddr2)) begin
        w_hit2 = 1'b1;
        w_byp2 = w_age_entry[k].data;
      end
    end
  end

  // Capture the bypass result at read accept for use in the response cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_byp_hit1 <= 1'b0;
      r_byp_hit2 <= 1'b0;
      r_byp_val1 <= '0;
      r_byp_val2 <= '0;
    end else if (w_rd_fire) begin
      r_byp_hit1 <= w_hit1;
      r_byp_hit2 <= w_hit2;
      r_byp_val1 <= w_byp1;
      r_byp_val2 <= w_byp2;
    end
  end

  assign bus.RdRespData1 = r_byp_hit1 ? r_byp_val1 : bus.ReadData1;
  assign bus.RdRespData2 = r_byp_hit2 ? r_byp_val2 : bus.ReadData2;
`else
  assign bus.RdRespData1 = bus.ReadData1;
  assign bus.RdRespData2 = bus.ReadData2;
`endif

  // The entry view only feeds the bypass compare; fold it away otherwise.
  logic w_unused_age;
  assign w_unused_age = ^{w_age_entry, w_age_vld};

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl. The bench also models the
// register file (synchronous write, combinational read, x0 reads zero).
module tb_regfile_port_ctrl;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  regfile_port_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_port_ctrl #(.DEPTH(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Register file model; it is not reset by the controller's reset.
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge Clk) begin
    if (bus.RegWrite && bus.WriteReg != 5'd0) rf[bus.WriteReg] <= bus.WriteData;
  end
  assign bus.ReadData1 = (bus.ReadReg1 == 5'd0) ? 32'h0 : rf[bus.ReadReg1];
  assign bus.ReadData2 = (bus.ReadReg2 == 5'd0) ? 32'h0 : rf[bus.ReadReg2];

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    int          at_cyc;
  } rexp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a response or a
  // register-file write.
  rexp_t m_r;
  wexp_t m_w;
  always @(negedge Clk) begin
    if (bus.RdRespValid) begin
      if (rq.size() == 0) begin
        chk("rd_resp_unexpected", 1, 0);
      end else begin
        m_r = rq.pop_front();
        chk("rd_data1", bus.RdRespData1, m_r.d1);
        chk("rd_data2", bus.RdRespData2, m_r.d2);
        chk("rd_latency", cyc, m_r.at_cyc);
      end
    end
    if (bus.RegWrite) begin
      if (wq.size() == 0) begin
        chk("regwrite_unexpected", 1, 0);
      end else begin
        m_w = wq.pop_front();
        chk("regwrite_addr", bus.WriteReg, m_w.addr);
        chk("regwrite_data", bus.WriteData, m_w.data);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Issue one write; waits is the number of cycles spent stalled.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, output int waits);
    bit ok;
    ok = 1'b1;
    waits = 0;
    bus.WrReqValid = 1'b1;
    bus.WrReqAddr  = a;
    bus.WrReqData  = d;
    @(negedge Clk);
    while (!bus.WrReqReady) begin
      waits++;
      if (waits > 50) begin
        ok = 1'b0;
        chk("wr_req_timeout", 0, 1);
        break;
      end
      @(negedge Clk);
    end
    if (ok && a != 5'd0) wq.push_back('{addr: a, data: d});
    @(posedge Clk);
    #1;
    bus.WrReqValid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    int waits;
    bit ok;
    ok = 1'b1;
    waits = 0;
    bus.RdReqValid = 1'b1;
    bus.RdReqAddr1 = a1;
    bus.RdReqAddr2 = a2;
    @(negedge Clk);
    while (!bus.RdReqReady) begin
      waits++;
      if (waits > 50) begin
        ok = 1'b0;
        chk("rd_req_timeout", 0, 1);
        break;
      end
      @(negedge Clk);
    end
    if (ok) rq.push_back('{d1: e1, d2: e2, at_cyc: cyc + 1});
    @(posedge Clk);
    #1;
    bus.RdReqValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.WrReqValid = 1'b0;
    bus.WrReqAddr  = '0;
    bus.WrReqData  = '0;
    bus.RdReqValid = 1'b0;
    bus.RdReqAddr1 = '0;
    bus.RdReqAddr2 = '0;

    // Reset state
    idle(3);
    @(negedge Clk);
    chk("rst_wr_ready", bus.WrReqReady, 0);
    chk("rst_rd_ready", bus.RdReqReady, 0);
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_writereg", bus.WriteReg, 0);
    chk("rst_writedata", bus.WriteData, 0);
    chk("rst_readreg1", bus.ReadReg1, 0);
    chk("rst_readreg2", bus.ReadReg2, 0);
    chk("rst_rdrespvalid", bus.RdRespValid, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_wr_ready", bus.WrReqReady, 1);
    chk("post_rst_rd_ready", bus.RdReqReady, 1);
    chk("post_rst_rdresp1", bus.RdRespData1, 0);
    @(posedge Clk);
    #1;

    // Basic write/read, including a discarded write to x0
    wr(5'd1, 32'd123, w);
    wr(5'd2, 32'd456, w);
    wr(5'd3, 32'd789, w);
    wr(5'd0, 32'd789, w);
    idle(4);
    rd(5'd0, 5'd1, 32'd0, 32'd123);
    rd(5'd2, 5'd3, 32'd456, 32'd789);
    idle(2);

    // Bypass: read immediately after the write
    wr(5'd5, 32'h0000_AAAA, w);
    rd(5'd5, 5'd5, 32'h0000_AAAA, 32'h0000_AAAA);
    idle(3);

    // Youngest wins among back-to-back writes to the same register
    wr(5'd7, 32'd1, w);
    wr(5'd7, 32'd2, w);
    wr(5'd7, 32'd3, w);
    rd(5'd7, 5'd7, 32'd3, 32'd3);
    idle(4);
    chk("rf_x7_final", rf[7], 32'd3);

    // Full-rate burst of 10 writes: ready never drops, pointers wrap
    for (int i = 0; i < 10; i++) begin
      wr(5'(16 + i), 32'h1000 + 32'(i), w);
      chk("burst_no_stall", w, 0);
    end
    idle(4);
    for (int i = 0; i < 10; i += 2) begin
      rd(5'(16 + i), 5'(17 + i), 32'h1000 + 32'(i), 32'h1001 + 32'(i));
    end
    idle(2);

    // Reset mid-drain: x12 holds 0xC0DE beforehand
    wr(5'd12, 32'h0000_C0DE, w);
    idle(4);
    wr(5'd10, 32'h111, w);
    wr(5'd11, 32'h222, w);
    wr(5'd12, 32'h333, w);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_wr_ready", bus.WrReqReady, 0);
    chk("midrst_rd_ready", bus.RdReqReady, 0);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("midrst_regwrite", bus.RegWrite, 0);
    chk("midrst_writereg", bus.WriteReg, 0);
    chk("midrst_writedata", bus.WriteData, 0);
    chk("midrst_readreg1", bus.ReadReg1, 0);
    chk("midrst_readreg2", bus.ReadReg2, 0);
    chk("midrst_rdrespvalid", bus.RdRespValid, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    // Only the write still queued at the reset edge (x12=0x333) is dropped.
    chk("midrst_dropped_writes", wq.size(), 1);
    wq.delete();
    idle(4);
    rd(5'd10, 5'd11, 32'h111, 32'h222);
    rd(5'd12, 5'd12, 32'h0000_C0DE, 32'h0000_C0DE);
    idle(5);

    chk("rd_scoreboard_empty", rq.size(), 0);
    chk("wr_scoreboard_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Initiator-side controller for the 32x32 register file. It takes write-back requests and operand-read requests from the datapath over valid/ready handshakes and drives the register file's `WriteReg`/`WriteData`/`RegWrite` and `ReadReg1`/`ReadReg2` ports. Pending writes are held in a small queue, and reads are either serviced with read-after-write bypass or stalled until the queue drains. It sits between the ALU write-back path and `RegisterFile`.

## Interface
Parameters:
- `DEPTH`, 4: write-queue entries; must be a power of 2, ≥ 2.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.

Ports:
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `WrReqValid`  in  1  write request present.
- `WrReqReady`  out  1  write request accepted this cycle.
- `WrReqAddr`  in  ADDR_W  destination register.
- `WrReqData`  in  DATA_W  write value.
- `RdReqValid`  in  1  read request present.
- `RdReqReady`  out  1  read request accepted this cycle.
- `RdReqAddr1`, `RdReqAddr2`  in  ADDR_W  source registers.
- `RdRespValid`  out  1  read response valid (one-cycle pulse).
- `RdRespData1`, `RdRespData2`  out  DATA_W  read results.
- `RegWrite`  out  1  register-file write enable (registered).
- `WriteReg`  out  ADDR_W  register-file write address (registered).
- `WriteData`  out  DATA_W  register-file write data (registered).
- `ReadReg1`, `ReadReg2`  out  ADDR_W  register-file read addresses (registered).
- `ReadData1`, `ReadData2`  in  DATA_W  register-file combinational read data.

## Operation
- **Write accept:** a write transfers when `WrReqValid && WrReqReady`. `WrReqReady = !full`, computed from the registered count. There is no same-cycle pass-through when the queue is full.
- **Writes to x0:** accepted but discarded. They are never enqueued and never reach `RegWrite`.
- **Drain:** when the queue is non-empty, the head is popped each cycle into the output register. That drives `RegWrite=1`, `WriteReg`, and `WriteData` for exactly one cycle. When the queue is empty, the next cycle has `RegWrite=0`. The register file commits at the following edge.
- **Read accept:** a read transfers when `RdReqValid && RdReqReady`. At that edge:
  - `ReadReg1`/`ReadReg2` load the requested addresses.
  - A bypass hit/value is captured for each operand.
- **Read response:** in the next cycle, `RdRespValid=1`. Each `RdRespDataN` equals the captured bypass value on a hit, otherwise `ReadDataN`.
- **Ordering:** a read accepted in the same cycle as a write sees the register state *before* that write.
- **Bypass priority:** youngest queue entry first, then the in-flight output register (`RegWrite=1`), then the register file.
- **Reset:** while `Reset=1` the block clears:
  - queue, count, pointers;
  - `RegWrite`, `WriteReg`, `WriteData`, `ReadReg1`, `ReadReg2`, `RdRespValid` all 0;
  - bypass captures.

  `WrReqReady` and `RdReqReady` are 0 during reset. `RdRespData*` reads x0 (0) after reset. Reset mid-drain discards all queued writes.

## Timing
- Write accepted at edge E is enqueued at E. It is driven on `RegWrite` at the earliest in the cycle after edge E+1 and committed in the register file at E+2 (queue empty case).
- Read latency: 1 cycle (accept at edge N, `RdRespValid` high during cycle N+1). Sustained throughput is one read per cycle.
- Drain throughput: one write per cycle. With full-rate input, `WrReqReady` stays 1 because enqueue and pop happen on the same edge.
- **Full:** `WrReqReady=0`. The entry popped at that edge frees a slot for the next cycle only.
- **Wrap-around:** pointers are `log2(DEPTH)` bits and wrap naturally; the count is `log2(DEPTH)+1` bits.

## Configuration
- **`REGFILE_PORT_BYPASS_EN` defined:** read-after-write bypass as above; `RdReqReady = !Reset`.
- **`REGFILE_PORT_BYPASS_EN` undefined:** no comparators.
  - `RdReqReady = !Reset && queue empty && !RegWrite`, so reads stall until every pending write has committed.
  - `RdRespDataN = ReadDataN`.

## Structure
- Package `regfile_pkg` holds:
  - `ADDR_W` and `DATA_W` constants;
  - `wq_entry_t` (addr, data) struct;
  - the x0 address constant.
- One sub-module, `regfile_wq_fifo`: a synchronous FIFO of `wq_entry_t` with push/pop, full/empty, and a parallel entry/valid view for the bypass compare.

## Test plan
- **Basic write/read:** after reset, write x1=123, x2=456, x3=789, and x0=789 on consecutive cycles; once idle, read (x0, x1) then (x2, x3). Required: (0, 123) and (456, 789), each one cycle after accept.
- **Bypass:** write x5=0xAAAA, then read (x5, x5) on the next cycle. With the macro: response 0xAAAA on both operands one cycle later. Without it: `RdReqReady` low until `RegWrite` deasserts, then 0xAAAA.
- **Youngest wins:** queue x7=1, x7=2, x7=3 back-to-back and read x7 immediately. Required: 3 (bypass build). The final register-file value is 3.
- **Full:** hold the register-file side busy with 4 back-to-back writes plus a 5th request. Required: `WrReqReady` drops only when count=DEPTH, and no write is lost or duplicated. Verify pointer wrap over 10 writes.
- **Reset mid-operation:** assert `Reset` with 3 writes queued. Required: all outputs 0 the next cycle, no further `RegWrite` pulses, and a subsequent read of those registers returns pre-reset register-file contents.
